// File: rtl/bitwise_oper_acc.sv
// bitwise_oper_acc
//   Per-beat selectable bitwise operation on two N-bit operands, or XOR-checksum
//   folding across a multi-beat frame. One registered stage from input to output,
//   followed by a main/skid output buffer so full throughput survives backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (registered state only, plus rst)
//   a, b       N-bit operands
//   op         operation select, sampled with the beat
//   in_last    last beat of frame
//   out_valid  result valid
//   out_ready  consumer accepts result
//   co         N-bit result
//   out_last   result closes a frame
//   out_cnt    number of beats folded into the result (saturating)
module bitwise_oper_acc #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [2:0]    op,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  co,
    output logic          out_last,
    output logic [CW-1:0] out_cnt
);

    localparam logic [2:0]    OpXor  = 3'd0;
    localparam logic [2:0]    OpAnd  = 3'd1;
    localparam logic [2:0]    OpOr   = 3'd2;
    localparam logic [2:0]    OpXnor = 3'd3;
    localparam logic [2:0]    OpNand = 3'd4;
    localparam logic [2:0]    OpNor  = 3'd5;
    localparam logic [2:0]    OpAcc  = 3'd6;
    localparam logic [2:0]    OpPass = 3'd7;
    localparam logic [CW-1:0] CntOne = CW'(1);
    localparam logic [CW-1:0] CntMax = '1;

    typedef enum logic {StIdle, StAcc} acc_state_e;

    acc_state_e    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          main_valid_q, main_valid_d;
    logic [N-1:0]  main_co_q, main_co_d;
    logic          main_last_q, main_last_d;
    logic [CW-1:0] main_cnt_q, main_cnt_d;
    logic          skid_valid_q, skid_valid_d;
    logic [N-1:0]  skid_co_q, skid_co_d;
    logic          skid_last_q, skid_last_d;
    logic [CW-1:0] skid_cnt_q, skid_cnt_d;

    logic          accept;
    logic          out_fire;
    logic          is_acc;
    logic [N-1:0]  acc_base;
    logic [CW-1:0] cnt_inc;
    logic          res_valid;
    logic [N-1:0]  res_co;
    logic          res_last;
    logic [CW-1:0] res_cnt;

    assign in_ready  = !rst && !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign out_valid = !rst && main_valid_q;
    assign co        = rst ? '0 : main_co_q;
    assign out_last  = rst ? 1'b0 : main_last_q;
    assign out_cnt   = rst ? '0 : main_cnt_q;
    assign out_fire  = out_valid && out_ready;

    assign is_acc   = (op == OpAcc);
    assign acc_base = (state_q == StAcc) ? acc_q : '0;
    assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    // Accumulator state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Accumulator next state; non-ACC beats leave an open frame untouched
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (accept && is_acc) begin
            if (in_last) begin
                state_d = StIdle;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = StAcc;
                acc_d   = acc_base ^ a ^ b;
                cnt_d   = (state_q == StAcc) ? cnt_inc : CntOne;
            end
        end
    end

    // Result produced by the beat being accepted this cycle
    always_comb begin
        res_valid = accept && (!is_acc || in_last);
        res_last  = in_last;
        res_cnt   = CntOne;
        res_co    = '0;
        case (op)
            OpXor:   res_co = a ^ b;
            OpAnd:   res_co = a & b;
            OpOr:    res_co = a | b;
            OpXnor:  res_co = ~(a ^ b);
            OpNand:  res_co = ~(a & b);
            OpNor:   res_co = ~(a | b);
            OpAcc: begin
                res_co   = acc_base ^ a ^ b;
                res_last = 1'b1;
                res_cnt  = (state_q == StAcc) ? cnt_inc : CntOne;
            end
            OpPass:  res_co = a;
            default: res_co = '0;
        endcase
    end

    // Output buffer: main feeds the port, skid absorbs one result under backpressure.
    // A new result never arrives while skid is full because in_ready is low then.
    always_comb begin
        main_valid_d = main_valid_q;
        main_co_d    = main_co_q;
        main_last_d  = main_last_q;
        main_cnt_d   = main_cnt_q;
        skid_valid_d = skid_valid_q;
        skid_co_d    = skid_co_q;
        skid_last_d  = skid_last_q;
        skid_cnt_d   = skid_cnt_q;
        if (out_fire) begin
            if (skid_valid_q) begin
                main_co_d    = skid_co_q;
                main_last_d  = skid_last_q;
                main_cnt_d   = skid_cnt_q;
                skid_valid_d = 1'b0;
            end else if (res_valid) begin
                main_co_d    = res_co;
                main_last_d  = res_last;
                main_cnt_d   = res_cnt;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (res_valid) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_co_d    = res_co;
                main_last_d  = res_last;
                main_cnt_d   = res_cnt;
            end else begin
                skid_valid_d = 1'b1;
                skid_co_d    = res_co;
                skid_last_d  = res_last;
                skid_cnt_d   = res_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_co_q    <= '0;
            main_last_q  <= 1'b0;
            main_cnt_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_co_q    <= '0;
            skid_last_q  <= 1'b0;
            skid_cnt_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_co_q    <= main_co_d;
            main_last_q  <= main_last_d;
            main_cnt_q   <= main_cnt_d;
            skid_valid_q <= skid_valid_d;
            skid_co_q    <= skid_co_d;
            skid_last_q  <= skid_last_d;
            skid_cnt_q   <= skid_cnt_d;
        end
    end

endmodule

// File: doc/bitwise_oper_acc.md
# bitwise_oper_acc

Parametrised successor to the team's registered bitwise-operator blocks. It applies a per-beat selectable bitwise operation to two N-bit operands, or accumulates an XOR checksum across a multi-beat frame. Input and output use valid/ready handshakes, and a 2-entry output buffer (main plus skid) sustains full throughput under backpressure. It sits between operand producers and downstream consumers in datapaths that need checksum/parity folding.

## Interface
- N, 4, operand/result width (N >= 1)
- CW, 8, beat-counter width (CW >= 1)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- a  in  N  operand A
- b  in  N  operand B
- op  in  3  operation select, sampled with beat
- in_last  in  1  last beat of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- co  out  N  result
- out_last  out  1  result closes a frame
- out_cnt  out  CW  beats represented by result

## Operation
- Beat accepted on a rising edge where in_valid && in_ready; result accepted where out_valid && out_ready.
- op encoding:
  - 0 XOR
  - 1 AND
  - 2 OR
  - 3 XNOR
  - 4 NAND
  - 5 NOR
  - 6 ACC_XOR
  - 7 PASS (co = a)
- Ops 0-5 and 7 each produce one result:
  - out_cnt = 1.
  - out_last = in_last of that beat.
- Accumulator FSM, states IDLE and ACC. Registers acc[N] and cnt[CW].
  - IDLE, ACC_XOR beat, in_last=0: acc <= a^b, cnt <= 1, go to ACC. No output.
  - IDLE, ACC_XOR beat, in_last=1: emit co = a^b, out_cnt=1, out_last=1. Stay IDLE.
  - ACC, ACC_XOR beat, in_last=0: acc <= acc^a^b, cnt <= sat(cnt+1). No output.
  - ACC, ACC_XOR beat, in_last=1: emit co = acc^a^b, out_cnt = sat(cnt+1), out_last=1. Clear acc and cnt, go to IDLE.
  - A non-ACC beat in ACC is processed normally. acc, cnt and state are unchanged, and the frame stays open.
  - cnt saturates at 2^CW-1; it never wraps.
- Output buffer states:
  - EMPTY
  - ONE (main valid)
  - TWO (main + skid valid)
- A result-producing beat is written to main if main is free or being consumed this cycle; otherwise it goes to skid.
- When main is consumed, skid moves to main on the same edge.
- in_ready = !rst && !skid_valid. A non-producing (accumulating) beat is accepted under the same rule.
- Results leave in strict acceptance order. No result is ever dropped or duplicated.
- Reset:
  - Outputs: out_valid=0, co=0, out_last=0, out_cnt=0, in_ready=0 while rst=1.
  - Internal: FSM goes to IDLE, acc=0, cnt=0, buffer goes to EMPTY.
  - Reset mid-frame discards the partial frame and any buffered results.

## Timing
- Latency: a beat accepted at edge E shows its result on co/out_valid in the cycle after E. This is one registered stage, with no combinational path from a/b to co.
- in_ready depends only on registered state. out_ready does not combinationally affect in_ready within the same cycle.
- With out_ready held at 1: 1 beat per cycle, sustained.
- With out_ready=0: at most two results held. in_ready drops the cycle after skid fills, and rises the cycle after main is consumed.
- A beat accepted on the same edge as a result consumption in state TWO is impossible (in_ready=0).
- co, out_last and out_cnt hold stable while out_valid && !out_ready.
- The first beat is accepted on the first edge after rst deasserts.

## Test plan
- Reset release, N=4: out_valid=0, co=0, out_cnt=0 during reset; in_ready=1 the cycle after rst falls.
- Ops 0-5,7 on a=4'b1100, b=4'b1010, out_ready=1, back-to-back -> co sequence 0110, 1000, 1110, 1001, 0111, 0001, 1100, one per cycle, latency 1, out_cnt=1.
- ACC_XOR frame of 3 beats, (a,b) = (1,2), (4,0), (8,8), last on beat 3 -> single result co=4'b0111, out_cnt=3, out_last=1; no out_valid on beats 1-2.
- Backpressure: out_ready=0, send XOR beats 1^0, 2^0, 3^0 -> in_ready drops after two accepted; third held. Then out_ready=1 -> outputs 1, 2, 3 in order, no loss.
- CW=2, ACC frame of 6 beats -> out_cnt saturates at 3. An interleaved AND beat mid-frame produces its own result and does not disturb acc.
- Assert rst after 2 accumulating beats, then send a 1-beat ACC frame a=5, b=0, last=1 -> co=5, out_cnt=1; no stale accumulator content.
